// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO's write-side and read-side
// pointer blocks: Gray/binary conversion and pointer-width derivation.
package async_fifo_pkg;

  // Widest pointer the helpers support; callers zero-extend into this width.
  localparam int MAX_PW = 16;

  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
    logic [MAX_PW-1:0] b;
    b[MAX_PW-1] = g[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and flag generator for the asynchronous FIFO: keeps the
// binary/Gray write pointers and derives full, almost-full and fill level.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int AFULL_TH = 6,
  localparam int PW      = ptr_width(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [PW-1:0]     wq2_rptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              wclken,
  output logic [PW-1:0]     wptr,
  output logic              wfull,
  output logic              wafull,
  output logic [PW-1:0]     wlevel,
  output logic              wr_ovf
);

  // Full means the write pointer is one lap ahead: the top two Gray bits differ.
  localparam logic [PW-1:0] FULL_FLIP = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin;
  logic          push;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          afull_next;

  always_comb begin
    push       = wr_en & ~wfull;
    wbin_next  = wbin + PW'(push);
    wgray_next = PW'(bin2gray(MAX_PW'(wbin_next)));
    rbin_s     = PW'(gray2bin(MAX_PW'(wq2_rptr)));
    level_next = wbin_next - rbin_s;
    full_next  = (wgray_next == (wq2_rptr ^ FULL_FLIP));
    afull_next = (level_next >= PW'(AFULL_TH));
  end

  assign wclken = push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      waddr  <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
      wr_ovf <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wptr   <= wgray_next;
      waddr  <= wbin_next[ADDR_W-1:0];
      wfull  <= full_next;
      wafull <= afull_next;
      wlevel <= level_next;
      wr_ovf <= wr_en & wfull;
    end
  end

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Self-checking bench for async_fifo_wptr_full: directed scenarios with literal
// expectations plus randomized pushes against a counting model of the FIFO.
module tb_async_fifo_wptr_full;

  localparam int ADDR_W   = 3;
  localparam int AFULL_TH = 6;
  localparam int PW       = 4;
  localparam int DEPTH    = 8;
  localparam int PMOD     = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [PW-1:0] wq2_rptr = '0;
  logic [ADDR_W-1:0] waddr;
  logic          wclken;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic          wafull;
  logic [PW-1:0] wlevel;
  logic          wr_ovf;

  async_fifo_wptr_full #(.ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wq2_rptr(wq2_rptr),
    .waddr(waddr), .wclken(wclken), .wptr(wptr), .wfull(wfull),
    .wafull(wafull), .wlevel(wlevel), .wr_ovf(wr_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: number of words pushed (mod 16) and the flags seen after the edge.
  int m_wbin  = 0;
  int m_lvl   = 0;
  bit m_full  = 1'b0;
  bit m_afull = 1'b0;
  bit m_ovf   = 1'b0;
  bit chkEn   = 1'b0;
  bit stepOk  = 1'b0;
  logic [PW-1:0] prevWptr = '0;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & (PMOD - 1);
  endfunction

  // Decode by search so the model does not share the RTL's conversion.
  function automatic int ungray(input logic [PW-1:0] g);
    for (int n = 0; n < PMOD; n++) begin
      if (gray(n) == int'(g)) return n;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit we, input logic [PW-1:0] rq);
    int wc, rb, lvl;
    bit nFull, nAfull, nOvf;
    rst_n    = r;
    wr_en    = we;
    wq2_rptr = rq;
    if (!r) begin
      wc = 0; lvl = 0; nFull = 0; nAfull = 0; nOvf = 0;
    end else begin
      wc     = (m_wbin + ((we && !m_full) ? 1 : 0)) % PMOD;
      rb     = ungray(rq);
      lvl    = ((wc - rb) % PMOD + PMOD) % PMOD;
      nFull  = (lvl == DEPTH);
      nAfull = (lvl >= AFULL_TH);
      nOvf   = we && m_full;
    end
    @(posedge clk);
    #1;
    m_wbin  = wc;
    m_lvl   = lvl;
    m_full  = nFull;
    m_afull = nAfull;
    m_ovf   = nOvf;
    stepOk  = r && chkEn;
    if (!r) chkEn = 1'b1;
  endtask

  // Every cycle after the first reset, all outputs must agree with the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("wptr",   int'(wptr),   gray(m_wbin));
      checkOutput("waddr",  int'(waddr),  m_wbin % DEPTH);
      checkOutput("wfull",  int'(wfull),  int'(m_full));
      checkOutput("wafull", int'(wafull), int'(m_afull));
      checkOutput("wlevel", int'(wlevel), m_lvl);
      checkOutput("wr_ovf", int'(wr_ovf), int'(m_ovf));
      checkOutput("wclken", int'(wclken), int'(wr_en && !m_full));
      if (stepOk) begin
        checkOutput("wptr_step", int'($countones(wptr ^ prevWptr) <= 1), 1);
      end
      prevWptr = wptr;
    end
  end

  initial begin
    logic [PW-1:0] seqExp [8];
    logic [PW-1:0] d1, d2, s1, s2;
    int rcnt, rdPct, occ;
    seqExp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};

    // Reset then idle
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("idle_wptr",   int'(wptr),   0);
    checkOutput("idle_wlevel", int'(wlevel), 0);
    checkOutput("idle_wfull",  int'(wfull),  0);
    checkOutput("idle_wr_ovf", int'(wr_ovf), 0);

    // Eight back-to-back pushes with the read pointer parked at zero
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 4'b0000);
      checkOutput("fill_wptr",  int'(wptr),  int'(seqExp[i-1]));
      checkOutput("fill_waddr", int'(waddr), i % 8);
      if (i == 5) checkOutput("fill_wafull5", int'(wafull), 0);
      if (i == 6) checkOutput("fill_wafull6", int'(wafull), 1);
      if (i == 7) checkOutput("fill_wfull7",  int'(wfull),  0);
    end
    checkOutput("full_wfull",  int'(wfull),  1);
    checkOutput("full_wlevel", int'(wlevel), 8);

    // Push attempts while full
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 4'b0000);
      checkOutput("ovf_pulse",  int'(wr_ovf), 1);
      checkOutput("ovf_wptr",   int'(wptr),   12);
      checkOutput("ovf_wclken", int'(wclken), 0);
    end

    // One read seen from full, then one push refills it
    applyStimulus(1'b1, 1'b0, 4'b0001);
    checkOutput("drain_wfull",  int'(wfull),  0);
    checkOutput("drain_wlevel", int'(wlevel), 7);
    checkOutput("drain_wafull", int'(wafull), 1);
    applyStimulus(1'b1, 1'b1, 4'b0001);
    checkOutput("refill_wfull", int'(wfull), 1);
    checkOutput("refill_wptr",  int'(wptr),  13);

    // Streaming with the read pointer trailing two cycles behind
    applyStimulus(1'b0, 1'b0, 4'b0000);
    d1 = '0; d2 = '0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b1, d2);
      d2 = d1;
      d1 = PW'(gray(m_wbin));
      checkOutput("stream_nofull", int'(wfull), 0);
      if (i == 15) checkOutput("stream_wptr15", int'(wptr), 8);
      if (i == 16) checkOutput("stream_wptr16", int'(wptr), 0);
    end

    // Reset in the middle of traffic
    applyStimulus(1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("pre_rst_wptr", int'(wptr), 7);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("rst_wptr",   int'(wptr),   0);
    checkOutput("rst_waddr",  int'(waddr),  0);
    checkOutput("rst_wlevel", int'(wlevel), 0);
    checkOutput("rst_wafull", int'(wafull), 0);
    checkOutput("rst_wr_ovf", int'(wr_ovf), 0);

    // Randomized traffic with a legal reader behind a two-stage pointer delay
    rcnt = 0; s1 = '0; s2 = '0;
    for (int c = 0; c < 1500; c++) begin
      rdPct = (c < 500) ? 20 : ((c < 1000) ? 75 : 45);
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'b0000);
        rcnt = 0; s1 = '0; s2 = '0;
      end else begin
        applyStimulus(1'b1, ($urandom_range(0, 99) < 60), s2);
        s2 = s1;
        s1 = PW'(gray(rcnt));
        occ = ((m_wbin - rcnt) % PMOD + PMOD) % PMOD;
        if (occ != 0 && $urandom_range(0, 99) < rdPct) rcnt = (rcnt + 1) % PMOD;
      end
    end

    applyStimulus(1'b1, 1'b0, s2);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/async_fifo_wptr_full.md
Name: async_fifo_wptr_full

Overview:
- Write-domain pointer and flag generator for the team's asynchronous FIFO.
- Runs on the write clock and maintains binary and Gray write pointers.
- Drives write address and write enable to the dual-port RAM.
- Computes full, almost-full and fill level from the read pointer after the two-flop pointer synchroniser has brought it into this domain.
- Its Gray output wptr is the data input of the write-to-read synchroniser.

Parameters:
ADDR_W, 3, RAM address width; depth = 2**ADDR_W; pointer width PW = ADDR_W+1 (must be >= 2)
AFULL_TH, 6, wafull asserts when fill level >= AFULL_TH (range 1..2**ADDR_W)

Ports:
clk  input  1  write-domain clock
rst_n  input  1  reset, synchronous, active-low
wr_en  input  1  push request from the write-side client
wq2_rptr  input  PW  read pointer (Gray), already synchronised into clk domain
waddr  output  ADDR_W  RAM write address (registered)
wclken  output  1  RAM write strobe; wr_en & ~wfull (combinational)
wptr  output  PW  write pointer, Gray, registered; to synchroniser
wfull  output  1  FIFO full, registered
wafull  output  1  almost full, registered
wlevel  output  PW  fill level as seen from the write side, registered, 0..2**ADDR_W
wr_ovf  output  1  one-cycle pulse: wr_en asserted while wfull=1

Behaviour:
- Reset is synchronous, active-low. Reset is applied to rst_n, which is synchronous, active-low, on clock clk.
- Reset values: wbin=0, wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0, wr_ovf=0. Reset mid-operation discards all state on that edge; the read side must be reset in the same window.
- Push: push = wr_en & ~wfull. wclken equals push in the same cycle; the RAM captures data at waddr on that edge.
- Next-state values:
  - wbin_next = wbin + push (mod 2**PW).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Registered on each edge: wbin <= wbin_next, waddr <= wbin_next[ADDR_W-1:0], wptr <= wgray_next.
- Full: wfull <= (wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]}).
  - Sets in the cycle after the push that fills the FIFO (latency 1).
  - Clears one cycle after wq2_rptr changes. This makes it pessimistic by the synchroniser delay of 2 clk; this is required and safe.
- Level: rbin_s = gray2bin(wq2_rptr); wlevel <= (wbin_next - rbin_s) mod 2**PW.
  - Never exceeds 2**ADDR_W given a legal read side.
- Almost full: wafull <= (level_next >= AFULL_TH), where level_next is the same value loaded into wlevel.
- Overflow: wr_ovf <= wr_en & wfull. Pointers are unchanged and no RAM write occurs.
- Wrap-around: the binary pointer wraps from 2**PW-1 to 0. Gray wraps from {1,0..0} to 0. The MSB toggle distinguishes full from empty.
- wptr changes by at most one bit per clk edge. This is mandatory for CDC correctness; no other logic may drive wptr.
- Simultaneous push and read-pointer advance while full is impossible (push is blocked while full). A read advance while not full is simply reflected in the next wlevel.

Decomposition:
- Shared package async_fifo_pkg holds:
  - functions bin2gray(PW) and gray2bin(PW), parameterised via a width parameter or a fixed maximum width.
  - a localparam helper for PW derivation.
- The read-side pointer/empty block imports the same package.
- No sub-module is needed; gray2bin is a combinational function. The synchroniser is instantiated at the FIFO top, not inside this block.

Test Plan (ADDR_W=3, AFULL_TH=6):
- Reset then idle, wq2_rptr=0 -> wptr=0000, waddr=0, wfull=0, wafull=0, wlevel=0, wr_ovf=0.
- 8 back-to-back pushes, wq2_rptr held at 0000 -> wptr sequence 0001,0011,0010,0110,0111,0101,0100,1100; waddr 1..7,0; wafull=1 after the 6th push; wfull=1 the cycle after the 8th push; wlevel=8.
- wr_en held high while full -> wr_ovf=1 each such cycle, wclken=0, wptr stays 1100.
- From full, set wq2_rptr=0001 (gray of 1) -> wfull=0 and wlevel=7 one cycle later; wafull remains 1; a single push sets wfull=1 again and wptr=1101.
- Continuous push with wq2_rptr tracking wptr delayed 2 cycles for 20 pushes -> wptr passes 1000 (gray of 15) then 0000; wfull never asserts; exactly one bit of wptr changes per push.
- rst_n low for one cycle after 5 pushes -> next cycle all outputs are at reset values, with wlevel=0 given wq2_rptr=0.
